// File: rtl/lvt_pkg.sv
// Shared constants and helpers for the LVT write-port scheduler.
package lvt_pkg;

  localparam int unsigned NUM_WPORTS = 4;
  localparam int unsigned LVT_SEL_W  = 2;

  typedef logic [LVT_SEL_W-1:0] port_idx_t;

  // Next requester index in round-robin order, wrapping at n.
  function automatic int unsigned rr_next(input int unsigned idx, input int unsigned n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/lvt_wr_pick.sv
// Combinational round-robin scan: grants up to four distinct-address requesters,
// defers same-address losers and computes the next scan pointer.
module lvt_wr_pick
  import lvt_pkg::*;
#(
  parameter int unsigned NREQ   = 6,
  parameter int unsigned ADDR_W = 11,
  parameter int unsigned PTR_W  = 3
) (
  input  logic [NREQ-1:0]                        valid_i,
  input  logic [ADDR_W-1:0]                      addr_i [NREQ],
  input  logic [PTR_W-1:0]                       rr_ptr_i,
  output logic [NREQ-1:0]                        grant_o,
  output logic [NREQ-1:0]                        defer_o,
  output logic [NUM_WPORTS-1:0]                  port_vld_o,
  output logic [NUM_WPORTS-1:0][PTR_W-1:0]       port_src_o,
  output logic [PTR_W-1:0]                       rr_ptr_o
);

  // Scan requesters from rr_ptr once around the ring, filling ports in order.
  always_comb begin
    logic [PTR_W-1:0]  idx;
    logic [2:0]        ng;
    logic              hit;
    logic              def_seen;
    logic [ADDR_W-1:0] gaddr [NUM_WPORTS];
    port_idx_t         slot;

    grant_o    = '0;
    defer_o    = '0;
    port_vld_o = '0;
    port_src_o = '0;
    rr_ptr_o   = rr_ptr_i;
    idx        = rr_ptr_i;
    ng         = 3'd0;
    hit        = 1'b0;
    def_seen   = 1'b0;
    slot       = '0;
    for (int unsigned p = 0; p < NUM_WPORTS; p++) gaddr[p] = '0;

    for (int unsigned k = 0; k < NREQ; k++) begin
      if (valid_i[idx]) begin
        hit = 1'b0;
        for (int unsigned p = 0; p < NUM_WPORTS; p++) begin
          if ((p < int'(ng)) && (gaddr[p] == addr_i[idx])) hit = 1'b1;
        end
        if (hit) begin
          defer_o[idx] = 1'b1;
          // The first loser becomes next cycle's top priority.
          if (!def_seen) begin
            def_seen = 1'b1;
            rr_ptr_o = idx;
          end
        end else if (ng < 3'(NUM_WPORTS)) begin
          slot              = ng[LVT_SEL_W-1:0];
          grant_o[idx]      = 1'b1;
          port_vld_o[slot]  = 1'b1;
          port_src_o[slot]  = idx;
          gaddr[slot]       = addr_i[idx];
          ng                = ng + 3'd1;
          if (!def_seen) rr_ptr_o = PTR_W'(rr_next(int'(idx), NREQ));
        end
      end
      idx = PTR_W'(rr_next(int'(idx), NREQ));
    end
  end

endmodule

// File: rtl/lvt_wr_sched.sv
// Write-port scheduler for the 2R/4W LVT RAM: round-robin arbitration of NREQ
// requesters onto four registered write ports with same-address suppression.
// Optional statistics counters are built when LVT_SCHED_STATS_EN is defined.
module lvt_wr_sched
  import lvt_pkg::*;
#(
  parameter int unsigned NREQ   = 6,
  parameter int unsigned ADDR_W = 11,
  parameter int unsigned DATA_W = 32
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic [NREQ-1:0]          req_valid_i,
  input  logic [NREQ*ADDR_W-1:0]   req_addr_i,
  input  logic [NREQ*DATA_W-1:0]   req_data_i,
  output logic [NREQ-1:0]          req_ready_o,
  input  logic                     hold_i,
  output logic [ADDR_W-1:0]        w_addr_1_o,
  output logic [ADDR_W-1:0]        w_addr_2_o,
  output logic [ADDR_W-1:0]        w_addr_3_o,
  output logic [ADDR_W-1:0]        w_addr_4_o,
  output logic [DATA_W-1:0]        w_din_1_o,
  output logic [DATA_W-1:0]        w_din_2_o,
  output logic [DATA_W-1:0]        w_din_3_o,
  output logic [DATA_W-1:0]        w_din_4_o,
  output logic                     w_enb_1_o,
  output logic                     w_enb_2_o,
  output logic                     w_enb_3_o,
  output logic                     w_enb_4_o
`ifdef LVT_SCHED_STATS_EN
  ,
  output logic [31:0]              grant_cnt_o,
  output logic [31:0]              conflict_cnt_o
`endif
);

  localparam int unsigned PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [ADDR_W-1:0]                  addr_a [NREQ];
  logic [DATA_W-1:0]                  data_a [NREQ];
  logic [NREQ-1:0]                    valid_eff;
  logic [NREQ-1:0]                    grant;
  logic [NREQ-1:0]                    defer;
  logic [NUM_WPORTS-1:0]              port_vld;
  logic [NUM_WPORTS-1:0][PTR_W-1:0]   port_src;
  logic [PTR_W-1:0]                   rr_ptr_q, rr_ptr_d;
  logic [ADDR_W-1:0]                  w_addr_q [NUM_WPORTS];
  logic [DATA_W-1:0]                  w_din_q  [NUM_WPORTS];
  logic [NUM_WPORTS-1:0]              w_enb_q;

  for (genvar gi = 0; gi < NREQ; gi++) begin : g_unpack
    assign addr_a[gi] = req_addr_i[gi*ADDR_W +: ADDR_W];
    assign data_a[gi] = req_data_i[gi*DATA_W +: DATA_W];
  end

  // Hold and reset hide all requests, so no grants and the pointer stays put.
  assign valid_eff   = (rst_i || hold_i) ? '0 : req_valid_i;
  assign req_ready_o = grant;

  lvt_wr_pick #(
    .NREQ   (NREQ),
    .ADDR_W (ADDR_W),
    .PTR_W  (PTR_W)
  ) u_pick (
    .valid_i    (valid_eff),
    .addr_i     (addr_a),
    .rr_ptr_i   (rr_ptr_q),
    .grant_o    (grant),
    .defer_o    (defer),
    .port_vld_o (port_vld),
    .port_src_o (port_src),
    .rr_ptr_o   (rr_ptr_d)
  );

  // Register pointer and port drive; idle ports keep their last address/data.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rr_ptr_q <= '0;
      w_enb_q  <= '0;
      for (int unsigned p = 0; p < NUM_WPORTS; p++) begin
        w_addr_q[p] <= '0;
        w_din_q[p]  <= '0;
      end
    end else begin
      rr_ptr_q <= rr_ptr_d;
      w_enb_q  <= port_vld;
      for (int unsigned p = 0; p < NUM_WPORTS; p++) begin
        if (port_vld[p]) begin
          w_addr_q[p] <= addr_a[port_src[p]];
          w_din_q[p]  <= data_a[port_src[p]];
        end
      end
    end
  end

  assign w_addr_1_o = w_addr_q[0];
  assign w_addr_2_o = w_addr_q[1];
  assign w_addr_3_o = w_addr_q[2];
  assign w_addr_4_o = w_addr_q[3];
  assign w_din_1_o  = w_din_q[0];
  assign w_din_2_o  = w_din_q[1];
  assign w_din_3_o  = w_din_q[2];
  assign w_din_4_o  = w_din_q[3];
  assign w_enb_1_o  = w_enb_q[0];
  assign w_enb_2_o  = w_enb_q[1];
  assign w_enb_3_o  = w_enb_q[2];
  assign w_enb_4_o  = w_enb_q[3];

`ifdef LVT_SCHED_STATS_EN
  logic [31:0] grant_cnt_q, conflict_cnt_q;
  logic [32:0] grant_sum, conflict_sum;

  assign grant_sum    = {1'b0, grant_cnt_q} + 33'($countones(grant));
  assign conflict_sum = {1'b0, conflict_cnt_q} + 33'($countones(defer));

  // Saturating statistics counters.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      grant_cnt_q    <= '0;
      conflict_cnt_q <= '0;
    end else begin
      grant_cnt_q    <= grant_sum[32] ? '1 : grant_sum[31:0];
      conflict_cnt_q <= conflict_sum[32] ? '1 : conflict_sum[31:0];
    end
  end

  assign grant_cnt_o    = grant_cnt_q;
  assign conflict_cnt_o = conflict_cnt_q;
`endif

endmodule

// File: tb/tb_lvt_wr_sched.sv
// Self-checking bench for lvt_wr_sched: directed table, reset cases and
// randomized traffic against a queue-based reference model.
module tb_lvt_wr_sched;

  localparam int NREQ   = 6;
  localparam int ADDR_W = 11;
  localparam int DATA_W = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic hold = 1'b0;
  logic [NREQ-1:0]        valid = '0;
  logic [ADDR_W-1:0]      addr [NREQ];
  logic [DATA_W-1:0]      data [NREQ];
  logic [NREQ*ADDR_W-1:0] req_addr;
  logic [NREQ*DATA_W-1:0] req_data;
  logic [NREQ-1:0]        ready;
  logic [ADDR_W-1:0]      wa1, wa2, wa3, wa4;
  logic [DATA_W-1:0]      wd1, wd2, wd3, wd4;
  logic                   we1, we2, we3, we4;
`ifdef LVT_SCHED_STATS_EN
  logic [31:0]            grant_cnt, conflict_cnt;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model state
  int               m_ptr;
  logic [3:0]       m_enb;
  logic [ADDR_W-1:0] m_addr [4];
  logic [DATA_W-1:0] m_din  [4];

  always #5 clk = ~clk;

  always_comb begin
    for (int i = 0; i < NREQ; i++) begin
      req_addr[i*ADDR_W +: ADDR_W] = addr[i];
      req_data[i*DATA_W +: DATA_W] = data[i];
    end
  end

  lvt_wr_sched #(
    .NREQ   (NREQ),
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .req_valid_i (valid),
    .req_addr_i  (req_addr),
    .req_data_i  (req_data),
    .req_ready_o (ready),
    .hold_i      (hold),
    .w_addr_1_o  (wa1),
    .w_addr_2_o  (wa2),
    .w_addr_3_o  (wa3),
    .w_addr_4_o  (wa4),
    .w_din_1_o   (wd1),
    .w_din_2_o   (wd2),
    .w_din_3_o   (wd3),
    .w_din_4_o   (wd4),
    .w_enb_1_o   (we1),
    .w_enb_2_o   (we2),
    .w_enb_3_o   (we3),
    .w_enb_4_o   (we4)
`ifdef LVT_SCHED_STATS_EN
    ,
    .grant_cnt_o    (grant_cnt),
    .conflict_cnt_o (conflict_cnt)
`endif
  );

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [255:0] dut_ports();
    return {we1, we2, we3, we4, wa1, wa2, wa3, wa4, wd1, wd2, wd3, wd4};
  endfunction

  function automatic logic [255:0] model_ports();
    return {m_enb[0], m_enb[1], m_enb[2], m_enb[3],
            m_addr[0], m_addr[1], m_addr[2], m_addr[3],
            m_din[0], m_din[1], m_din[2], m_din[3]};
  endfunction

  task automatic model_reset();
    m_ptr = 0;
    m_enb = '0;
    for (int p = 0; p < 4; p++) begin
      m_addr[p] = '0;
      m_din[p]  = '0;
    end
  endtask

  // One arbitration cycle from the rules: scan from the pointer, skip
  // addresses already taken, grant up to four, remember losers.
  task automatic model_cycle(output logic [NREQ-1:0] rdy);
    int                granted[$];
    int                deferred[$];
    logic [ADDR_W-1:0] taken[$];
    bit                dup;
    rdy = '0;
    if (!hold) begin
      for (int k = 0; k < NREQ; k++) begin
        int i;
        i = (m_ptr + k) % NREQ;
        if (valid[i]) begin
          dup = 0;
          foreach (taken[t]) if (taken[t] == addr[i]) dup = 1;
          if (dup) deferred.push_back(i);
          else if (granted.size() < 4) begin
            granted.push_back(i);
            taken.push_back(addr[i]);
          end
        end
      end
    end
    foreach (granted[g]) rdy[granted[g]] = 1'b1;
    if (deferred.size() > 0) m_ptr = deferred[0];
    else if (granted.size() > 0) m_ptr = (granted[granted.size()-1] + 1) % NREQ;
    for (int p = 0; p < 4; p++) begin
      m_enb[p] = (p < granted.size());
      if (p < granted.size()) begin
        m_addr[p] = addr[granted[p]];
        m_din[p]  = data[granted[p]];
      end
    end
  endtask

  // Inputs already driven; check ready before the edge, ports after it.
  task automatic cycle(input string name, input bit chk, input logic [NREQ-1:0] exp_rdy);
    logic [NREQ-1:0] mr;
    #1;
    model_cycle(mr);
    check({name, "_ready_model"}, 256'(ready), 256'(mr));
    if (chk) check({name, "_ready_table"}, 256'(ready), 256'(exp_rdy));
    @(posedge clk);
    #1;
    check({name, "_ports"}, dut_ports(), model_ports());
  endtask

  typedef struct {
    logic [NREQ-1:0]              v;
    logic [NREQ-1:0][ADDR_W-1:0]  a;
    logic                         h;
    logic [NREQ-1:0]              exp;
  } vec_t;

  function automatic vec_t mk(input logic [NREQ-1:0] v, input int a0, input int a1,
                              input int a2, input int a3, input int a4, input int a5,
                              input logic h, input logic [NREQ-1:0] exp);
    vec_t r;
    r.v = v; r.h = h; r.exp = exp;
    r.a[0] = ADDR_W'(a0); r.a[1] = ADDR_W'(a1); r.a[2] = ADDR_W'(a2);
    r.a[3] = ADDR_W'(a3); r.a[4] = ADDR_W'(a4); r.a[5] = ADDR_W'(a5);
    return r;
  endfunction

  vec_t tbl [14];

  initial begin
    for (int i = 0; i < NREQ; i++) begin
      addr[i] = '0;
      data[i] = '0;
    end
    model_reset();

    tbl[0]  = mk(6'h3F, 0, 1, 2, 3, 4, 5, 0, 6'b001111);
    tbl[1]  = mk(6'h3F, 0, 1, 2, 3, 4, 5, 0, 6'b110011);
    tbl[2]  = mk(6'h20, 0, 1, 2, 3, 4, 5, 0, 6'b100000);
    tbl[3]  = mk(6'h05, 'h10, 1, 'h10, 3, 4, 5, 0, 6'b000001);
    tbl[4]  = mk(6'h04, 'h10, 1, 'h10, 3, 4, 5, 0, 6'b000100);
    tbl[5]  = mk(6'h10, 0, 1, 2, 3, 4, 5, 0, 6'b010000);
    tbl[6]  = mk(6'h21, 'h21, 1, 2, 3, 4, 'h20, 0, 6'b100001);
    tbl[7]  = mk(6'h3F, 0, 1, 2, 3, 4, 5, 1, 6'b000000);
    tbl[8]  = mk(6'h3F, 0, 1, 2, 3, 4, 5, 1, 6'b000000);
    tbl[9]  = mk(6'h3F, 0, 1, 2, 3, 4, 5, 1, 6'b000000);
    tbl[10] = mk(6'h3F, 0, 1, 2, 3, 4, 5, 0, 6'b011110);
    tbl[11] = mk(6'h3F, 7, 7, 7, 7, 7, 7, 0, 6'b100000);
    tbl[12] = mk(6'h3F, 7, 7, 7, 7, 7, 7, 0, 6'b000001);
    tbl[13] = mk(6'h3F, 'h0E, 'h0A, 'h0A, 'h0B, 'h0C, 'h0D, 0, 6'b111010);

    // Reset with every requester asking
    valid = '1;
    for (int i = 0; i < NREQ; i++) begin
      addr[i] = ADDR_W'(i + 1);
      data[i] = 32'hA000_0000 + i;
    end
    repeat (2) @(posedge clk);
    #1;
    check("reset_ready", 256'(ready), 256'(0));
    check("reset_ports", dut_ports(), 256'(0));
    valid = '0;
    @(negedge clk);
    rst = 1'b0;

    // Directed table
    for (int t = 0; t < 14; t++) begin
      valid = tbl[t].v;
      hold  = tbl[t].h;
      for (int i = 0; i < NREQ; i++) begin
        addr[i] = tbl[t].a[i];
        data[i] = 32'hD000_0000 + 32'(t * 16 + i);
      end
      cycle($sformatf("vec%0d", t), 1'b1, tbl[t].exp);
      if (t >= 7 && t <= 9) check($sformatf("hold_enb%0d", t), 256'({we1, we2, we3, we4}), 256'(0));
    end
    hold = 1'b0;

    // Randomized traffic with occasional mid-run reset
    for (int c = 0; c < 400; c++) begin
      valid = NREQ'($urandom);
      hold  = ($urandom_range(0, 7) == 0);
      for (int i = 0; i < NREQ; i++) begin
        addr[i] = ADDR_W'($urandom_range(0, 7));
        data[i] = $urandom;
      end
      if (c % 131 == 130) begin
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        check("midreset_ready", 256'(ready), 256'(0));
        check("midreset_ports", dut_ports(), model_ports());
        @(negedge clk);
        rst = 1'b0;
      end
      cycle("rand", 1'b0, '0);
    end
    hold = 1'b0;

`ifdef LVT_SCHED_STATS_EN
    // Two-way conflict: one grant and one deferral every cycle
    rst = 1'b1;
    #1;
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    valid = 6'b000101;
    addr[0] = 'h10;
    addr[2] = 'h10;
    for (int c = 0; c < 10; c++) cycle("stat_conf", 1'b0, '0);
    check("conflict_cnt", 256'(conflict_cnt), 256'(10));
    check("grant_cnt", 256'(grant_cnt), 256'(10));
    @(negedge clk);
    force dut.grant_cnt_q = 32'hFFFF_FFFE;
    #1;
    release dut.grant_cnt_q;
    valid = '1;
    for (int i = 0; i < NREQ; i++) addr[i] = ADDR_W'(i + 'h40);
    cycle("stat_sat", 1'b0, '0);
    check("grant_cnt_sat", 256'(grant_cnt), 256'(32'hFFFF_FFFF));
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
